vga_sync_receiver: RTL

Receive-side counterpart of the VGA timing generator: consumes active-low hSync/vSync and rebuilds hCount/vCount/bright locally. Checks line and frame timing against 640x480@60 parameters, reports lock, and flags timing errors. Used in board loopback and self-test of the display path. Runs on the 100 MHz board clock.

---
 rtl/vga_sync_receiver.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: rebuilds hCount/vCount/bright from active-low hSync/vSync,
// measures line length against the nominal 640x480@60 timing, tracks lock and
// pulses timing_err on lock-breaking events.
// Optional build macro: VGA_RX_ERRCNT_EN (saturating timing error counter).
module vga_sync_receiver #(
    parameter int unsigned PIX_DIV     = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT_END   = 784,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT_END   = 515,
    parameter int unsigned LINE_TOL    = 2,
    parameter int unsigned LOCK_LINES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hSync,
    input  logic       vSync,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       locked,
    output logic       frame_start,
    output logic       timing_err,
    output logic [7:0] err_count
);

    localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned GOOD_W   = $clog2(LOCK_LINES + 1);
    localparam int unsigned LINE_NOM = H_TOTAL * PIX_DIV - 1;
    localparam int unsigned LINE_MIN = LINE_NOM - LINE_TOL;
    localparam int unsigned LINE_MAX = LINE_NOM + LINE_TOL;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic               hs_meta_q, hs_sync_q, hs_hist_q;
    logic               vs_meta_q, vs_sync_q, vs_hist_q;
    logic               pend_q, pend_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [9:0]         hcnt_q, hcnt_d;
    logic [9:0]         vcnt_q, vcnt_d;
    logic [11:0]        clk_cnt_q, clk_cnt_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic               fs_q, err_q, err_d;

    logic hfall, vfall, pix_tick, frame_now, line_good, lost;

    assign hfall     = hs_hist_q & ~hs_sync_q;
    assign vfall     = vs_hist_q & ~vs_sync_q;
    assign pix_tick  = (div_q == DIV_W'(PIX_DIV - 1));
    assign frame_now = hfall & (pend_q | vfall);
    assign line_good = (clk_cnt_q >= 12'(LINE_MIN)) && (clk_cnt_q <= 12'(LINE_MAX));
    assign lost      = (clk_cnt_q == 12'd4094) & ~hfall;

    // Two-flop synchronizers plus a history flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_meta_q <= 1'b1;
            hs_sync_q <= 1'b1;
            hs_hist_q <= 1'b1;
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_hist_q <= 1'b1;
        end else begin
            hs_meta_q <= hSync;
            hs_sync_q <= hs_meta_q;
            hs_hist_q <= hs_sync_q;
            vs_meta_q <= vSync;
            vs_sync_q <= vs_meta_q;
            vs_hist_q <= vs_sync_q;
        end
    end

    // Pixel divider, position counters, line-length counter and vSync pending flag.
    always_comb begin
        div_d     = div_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        clk_cnt_d = clk_cnt_q;
        pend_d    = pend_q;
        if (hfall) begin
            div_d     = '0;
            hcnt_d    = '0;
            clk_cnt_d = '0;
            pend_d    = 1'b0;
            if (frame_now) begin
                vcnt_d = '0;
            end else if (vcnt_q != '1) begin
                vcnt_d = vcnt_q + 10'd1;
            end
        end else begin
            div_d = pix_tick ? '0 : div_q + DIV_W'(1);
            if (pix_tick && hcnt_q != '1) begin
                hcnt_d = hcnt_q + 10'd1;
            end
            if (clk_cnt_q != '1) begin
                clk_cnt_d = clk_cnt_q + 12'd1;
            end
            if (vfall) begin
                pend_d = 1'b1;
            end
        end
    end

    // Lock state machine: next state, good-line count and error pulse.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_SEARCH: begin
                if (hfall) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (hfall) begin
                    if (!line_good) begin
                        good_d = '0;
                    end else if (good_q != GOOD_W'(LOCK_LINES)) begin
                        good_d = good_q + GOOD_W'(1);
                    end
                    if (frame_now && good_q == GOOD_W'(LOCK_LINES)) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if ((hfall && (!line_good ||
                               (frame_now && vcnt_q != 10'(V_TOTAL - 1)))) || lost) begin
                    state_d = ST_SEARCH;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SEARCH;
            pend_q    <= 1'b0;
            div_q     <= '0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            clk_cnt_q <= '0;
            good_q    <= '0;
            fs_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            div_q     <= div_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            clk_cnt_q <= clk_cnt_d;
            good_q    <= good_d;
            fs_q      <= frame_now;
            err_q     <= err_d;
        end
    end

`ifdef VGA_RX_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    // Saturating count of lock-breaking events, visible with the error pulse.
    always_comb begin
        errcnt_d = errcnt_q;
        if (err_d && errcnt_q != '1) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign err_count = errcnt_q;
`else
    assign err_count = '0;
`endif

    assign hCount      = hcnt_q;
    assign vCount      = vcnt_q;
    assign locked      = (state_q == ST_LOCKED);
    assign frame_start = fs_q;
    assign timing_err  = err_q;
    assign bright      = locked &&
                         (hcnt_q >= 10'(H_ACT_START)) && (hcnt_q < 10'(H_ACT_END)) &&
                         (vcnt_q >= 10'(V_ACT_START)) && (vcnt_q < 10'(V_ACT_END));

endmodule
